// File: rtl/dphy_hs_lane_seq_if.sv
// rtl/dphy_hs_lane_seq_if.sv - burst request and payload byte handshake for the HS lane sequencer
interface dphy_hs_lane_seq_if;
   logic       tx_req_i;
   logic [7:0] data_i;
   logic       data_valid_i;
   logic       data_last_i;
   logic       data_ready_o;

   // upstream packet source
   modport master (
      output tx_req_i,
      output data_i,
      output data_valid_i,
      output data_last_i,
      input  data_ready_o
   );

   // lane sequencer
   modport slave (
      input  tx_req_i,
      input  data_i,
      input  data_valid_i,
      input  data_last_i,
      output data_ready_o
   );
endinterface

// File: rtl/dphy_hs_lane_seq.sv
// rtl/dphy_hs_lane_seq.sv - per-lane D-PHY HS burst sequencer (LP-11, LP-01, LP-00, HS-zero, sync, payload, trail)
module dphy_hs_lane_seq #(
   parameter int unsigned T_LPX     = 4,
   parameter int unsigned T_PREP    = 4,
   parameter int unsigned T_ZERO    = 8,
   parameter int unsigned T_TRAIL   = 4,
   parameter int unsigned T_EXIT    = 8,
   parameter logic [7:0]  SYNC_BYTE = 8'hB8
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   dphy_hs_lane_seq_if.slave   bus,
   output logic                lp_p_o,
   output logic                lp_n_o,
   output logic                hs_oe_o,
   output logic [7:0]          hs_byte_o,
   output logic                busy_o,
   output logic                err_o
);

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned T_MAX = max2(max2(max2(T_LPX, T_PREP), max2(T_ZERO, T_TRAIL)), T_EXIT);
   localparam int          CNT_W = $clog2(T_MAX) + 1;

   // A timed phase of length t occupies t cycles: load t-1, leave when the counter reads zero.
   function automatic logic [CNT_W-1:0] load(input int unsigned t);
      return CNT_W'(t - 1);
   endfunction

   // ST_LAST is the single DATA cycle holding the final byte; TRAIL always follows it.
   typedef enum logic [3:0] {
      ST_STOP,
      ST_LPX,
      ST_PREP,
      ST_ZERO,
      ST_SYNC,
      ST_DATA,
      ST_LAST,
      ST_TRAIL,
      ST_EXIT
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lp_p_q, lp_p_d;
   logic             lp_n_q, lp_n_d;
   logic             hs_oe_q, hs_oe_d;
   logic [7:0]       hs_byte_q, hs_byte_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic             cnt_zero;

   assign cnt_zero = (cnt_q == '0);

   // Next state, shared phase counter and the registered outputs of the state being entered.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = 1'b0;
      lp_p_d    = 1'b0;
      lp_n_d    = 1'b0;
      hs_oe_d   = 1'b0;
      hs_byte_d = 8'h00;
      ready_d   = 1'b0;

      case (state_q)
         ST_STOP: begin
            if (bus.tx_req_i) begin
               state_d = ST_LPX;
               cnt_d   = load(T_LPX);
            end
         end
         ST_LPX: begin
            if (cnt_zero) begin
               state_d = ST_PREP;
               cnt_d   = load(T_PREP);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_PREP: begin
            if (cnt_zero) begin
               state_d = ST_ZERO;
               cnt_d   = load(T_ZERO);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_ZERO: begin
            if (cnt_zero) begin
               state_d = ST_SYNC;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_SYNC, ST_DATA: begin
            if (bus.data_valid_i) begin
               state_d = bus.data_last_i ? ST_LAST : ST_DATA;
            end else begin
               // Source ran dry mid-burst: close the burst cleanly and flag it.
               state_d = ST_TRAIL;
               cnt_d   = load(T_TRAIL);
               err_d   = 1'b1;
            end
         end
         ST_LAST: begin
            state_d = ST_TRAIL;
            cnt_d   = load(T_TRAIL);
         end
         ST_TRAIL: begin
            if (cnt_zero) begin
               state_d = ST_EXIT;
               cnt_d   = load(T_EXIT);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_EXIT: begin
            if (cnt_zero) begin
               state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_STOP;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d != ST_STOP);

      case (state_d)
         ST_STOP, ST_EXIT: begin
            lp_p_d = 1'b1;
            lp_n_d = 1'b1;
         end
         ST_LPX: begin
            lp_n_d = 1'b1;
         end
         ST_ZERO: begin
            hs_oe_d = 1'b1;
         end
         ST_SYNC: begin
            hs_oe_d   = 1'b1;
            hs_byte_d = SYNC_BYTE;
            ready_d   = 1'b1;
         end
         ST_DATA: begin
            hs_oe_d   = 1'b1;
            hs_byte_d = bus.data_i;
            ready_d   = 1'b1;
         end
         ST_LAST: begin
            hs_oe_d   = 1'b1;
            hs_byte_d = bus.data_i;
         end
         ST_TRAIL: begin
            hs_oe_d = 1'b1;
            // Trail is the inverse of the final serialized bit (MSB of the last HS byte),
            // captured on TRAIL entry and held for the whole trail.
            hs_byte_d = (state_q == ST_TRAIL) ? hs_byte_q : {8{~hs_byte_q[7]}};
         end
         default: begin
         end
      endcase
   end

   // State, counter and output registers; reset drops straight to LP-11 with no trail.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_STOP;
         cnt_q     <= '0;
         lp_p_q    <= 1'b1;
         lp_n_q    <= 1'b1;
         hs_oe_q   <= 1'b0;
         hs_byte_q <= 8'h00;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lp_p_q    <= lp_p_d;
         lp_n_q    <= lp_n_d;
         hs_oe_q   <= hs_oe_d;
         hs_byte_q <= hs_byte_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   assign lp_p_o           = lp_p_q;
   assign lp_n_o           = lp_n_q;
   assign hs_oe_o          = hs_oe_q;
   assign hs_byte_o        = hs_byte_q;
   assign busy_o           = busy_q;
   assign err_o            = err_q;
   assign bus.data_ready_o = ready_q;

endmodule

// File: tb/tb_dphy_hs_lane_seq.sv
// tb/tb_dphy_hs_lane_seq.sv - self-checking bench for the HS lane sequencer
module tb_dphy_hs_lane_seq;
   localparam int         T_LPX     = 4;
   localparam int         T_PREP    = 4;
   localparam int         T_ZERO    = 8;
   localparam int         T_TRAIL   = 4;
   localparam int         T_EXIT    = 8;
   localparam logic [7:0] SYNC_BYTE = 8'hB8;

   typedef struct packed {
      logic       lp_p;
      logic       lp_n;
      logic       oe;
      logic [7:0] hb;
      logic       rdy;
      logic       busy;
      logic       err;
   } exp_t;

   localparam exp_t IDLE   = 14'h3000;
   localparam exp_t M_LP   = 14'h3000;
   localparam exp_t M_OE   = 14'h0800;
   localparam exp_t M_HB   = 14'h07F8;
   localparam exp_t M_RDY  = 14'h0004;
   localparam exp_t M_BUSY = 14'h0002;
   localparam exp_t M_ERR  = 14'h0001;
   localparam exp_t M_ALL  = 14'h3FFF;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       lp_p, lp_n, hs_oe, busy, err;
   logic [7:0] hs_byte;

   dphy_hs_lane_seq_if bus();

   dphy_hs_lane_seq #(
      .T_LPX(T_LPX), .T_PREP(T_PREP), .T_ZERO(T_ZERO),
      .T_TRAIL(T_TRAIL), .T_EXIT(T_EXIT), .SYNC_BYTE(SYNC_BYTE)
   ) dut (
      .clk_i(clk),
      .rst_n_i(rst_n),
      .bus(bus),
      .lp_p_o(lp_p),
      .lp_n_o(lp_n),
      .hs_oe_o(hs_oe),
      .hs_byte_o(hs_byte),
      .busy_o(busy),
      .err_o(err)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic p, input logic n, input logic oe, input logic [7:0] hb,
                               input logic rdy, input logic bsy, input logic e);
      exp_t r;
      r.lp_p = p; r.lp_n = n; r.oe = oe; r.hb = hb; r.rdy = rdy; r.busy = bsy; r.err = e;
      return r;
   endfunction

   function automatic string fmt(input exp_t e);
      return $sformatf("lp=%b%b oe=%b byte=%h rdy=%b busy=%b err=%b", e.lp_p, e.lp_n, e.oe, e.hb, e.rdy, e.busy, e.err);
   endfunction

   // ---------------- schedule model: a burst is a queue of per-cycle line states ----------------
   exp_t exp_q[$];
   exp_t cur;
   bit   model_valid = 1'b0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push_n(input exp_t e, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(e);
   endfunction

   function automatic void push_trail(input logic b, input logic e);
      for (int i = 0; i < T_TRAIL; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, {8{~b}}, 1'b0, 1'b1, (i == 0) ? e : 1'b0));
      push_n(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0), T_EXIT);
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         cur = IDLE;
         model_valid = 1'b1;
      end else if (model_valid) begin
         if (!cur.busy && bus.tx_req_i) begin
            push_n(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0), T_LPX);
            push_n(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0), T_PREP);
            push_n(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0), T_ZERO);
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, SYNC_BYTE, 1'b1, 1'b1, 1'b0));
         end else if (cur.rdy) begin
            if (bus.data_valid_i) begin
               exp_q.push_back(mk(1'b0, 1'b0, 1'b1, bus.data_i, ~bus.data_last_i, 1'b1, 1'b0));
               if (bus.data_last_i) push_trail(bus.data_i[7], 1'b0);
            end else begin
               push_trail(cur.hb[7], 1'b1);
            end
         end
         if (exp_q.size() != 0) cur = exp_q.pop_front();
         else cur = IDLE;
      end
   end

   // ---------------- hand-computed literal expectations per burst cycle ----------------
   exp_t lit_mask [64];
   exp_t lit_val  [64];
   int   base = 0;
   bit   rec_en = 1'b0;
   int   tmo_cnt = 0;

   task automatic clr_lit();
      for (int i = 0; i < 64; i++) begin
         lit_mask[i] = '0;
         lit_val[i]  = '0;
      end
   endtask

   task automatic lit(input int idx, input exp_t m, input exp_t v);
      lit_mask[idx] = m;
      lit_val[idx]  = v;
   endtask

   // ---------------- compare process ----------------
   int vectors = 0;
   int miscompares = 0;
   int tmo_seen = 0;

   always @(negedge clk) begin
      exp_t act;
      int   idx;
      act = mk(lp_p, lp_n, hs_oe, hs_byte, bus.data_ready_o, busy, err);
      if (model_valid) begin
         vectors++;
         if (act !== cur) begin
            miscompares++;
            $display("FAIL model cyc=%0d got %s expected %s", cyc, fmt(act), fmt(cur));
         end
      end
      idx = cyc - base;
      if (rec_en && idx >= 0 && idx < 64 && lit_mask[idx] != '0) begin
         vectors++;
         if ((act & lit_mask[idx]) !== (lit_val[idx] & lit_mask[idx])) begin
            miscompares++;
            $display("FAIL literal burst_cycle=%0d got %s expected %s (mask %h)", idx, fmt(act), fmt(lit_val[idx]), lit_mask[idx]);
         end
      end
      if (tmo_cnt != tmo_seen) begin
         vectors++;
         miscompares++;
         tmo_seen = tmo_cnt;
         $display("FAIL timeout burst did not return to STOP got busy=%b expected busy=0", busy);
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] pay [8];
   logic       busy_s;

   task automatic step(output bit acc);
      @(negedge clk);
      busy_s = busy;
      acc = bus.data_ready_o && bus.data_valid_i;
      @(posedge clk);
      #1;
   endtask

   // n payload bytes from pay[]; drop_after<0 never drops valid; rst_at<0 no reset pulse.
   task automatic run_burst(input int n, input int drop_after, input int rst_at, input bit hold, input bit started);
      bit acc;
      bit done;
      int idx;
      idx = 0;
      bus.data_i       = pay[0];
      bus.data_last_i  = (n == 1);
      bus.data_valid_i = (drop_after != 0);
      if (!started) begin
         bus.tx_req_i = 1'b1;
         step(acc);
      end
      base = cyc - 1;
      rec_en = 1'b1;
      bus.tx_req_i = hold;
      done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         if (cyc - base == rst_at) begin
            rst_n = 1'b0;
            bus.data_valid_i = 1'b0;
         end
         step(acc);
         rst_n = 1'b1;
         if (acc) begin
            idx++;
            if (idx >= n || idx == drop_after) begin
               bus.data_valid_i = 1'b0;
               bus.data_last_i  = 1'b0;
            end else begin
               bus.data_i      = pay[idx];
               bus.data_last_i = (idx == n - 1);
            end
         end
         if (!busy_s) done = 1'b1;
      end
      rec_en = 1'b0;
      if (!done) tmo_cnt++;
   endtask

   initial begin
      bit acc;
      rst_n = 1'b0;
      bus.tx_req_i = 1'b0;
      bus.data_i = 8'h00;
      bus.data_valid_i = 1'b0;
      bus.data_last_i = 1'b0;
      busy_s = 1'b0;
      clr_lit();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) step(acc);

      // basic burst 11, 22, 83(last)
      clr_lit();
      lit(1,  M_LP, mk(0, 1, 0, 8'h00, 0, 0, 0));
      lit(4,  M_LP, mk(0, 1, 0, 8'h00, 0, 0, 0));
      lit(5,  M_LP, mk(0, 0, 0, 8'h00, 0, 0, 0));
      lit(8,  M_LP | M_OE, mk(0, 0, 0, 8'h00, 0, 0, 0));
      lit(9,  M_OE | M_HB, mk(0, 0, 1, 8'h00, 0, 0, 0));
      lit(16, M_OE | M_HB, mk(0, 0, 1, 8'h00, 0, 0, 0));
      lit(17, M_OE | M_HB | M_RDY, mk(0, 0, 1, 8'hB8, 1, 0, 0));
      lit(18, M_HB, mk(0, 0, 0, 8'h11, 0, 0, 0));
      lit(19, M_HB | M_RDY, mk(0, 0, 0, 8'h22, 1, 0, 0));
      lit(20, M_HB | M_RDY, mk(0, 0, 0, 8'h83, 0, 0, 0));
      lit(21, M_OE | M_HB, mk(0, 0, 1, 8'h00, 0, 0, 0));
      lit(24, M_OE | M_HB, mk(0, 0, 1, 8'h00, 0, 0, 0));
      lit(25, M_LP | M_OE, mk(1, 1, 0, 8'h00, 0, 0, 0));
      lit(32, M_BUSY, mk(0, 0, 0, 8'h00, 0, 1, 0));
      lit(33, M_BUSY, mk(0, 0, 0, 8'h00, 0, 0, 0));
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h83;
      run_burst(3, -1, -1, 1'b0, 1'b0);

      // trail polarity, single byte 7F, ready low in its DATA cycle
      clr_lit();
      lit(18, M_HB | M_RDY, mk(0, 0, 0, 8'h7F, 0, 0, 0));
      lit(19, M_HB, mk(0, 0, 0, 8'hFF, 0, 0, 0));
      lit(22, M_OE | M_HB, mk(0, 0, 1, 8'hFF, 0, 0, 0));
      lit(23, M_OE, mk(0, 0, 0, 8'h00, 0, 0, 0));
      pay[0] = 8'h7F;
      run_burst(1, -1, -1, 1'b0, 1'b0);

      // trail polarity, single byte 80
      clr_lit();
      lit(18, M_HB, mk(0, 0, 0, 8'h80, 0, 0, 0));
      lit(19, M_HB | M_OE, mk(0, 0, 1, 8'h00, 0, 0, 0));
      pay[0] = 8'h80;
      run_burst(1, -1, -1, 1'b0, 1'b0);

      // underflow after 2 of 4 bytes
      clr_lit();
      lit(18, M_HB, mk(0, 0, 0, 8'h81, 0, 0, 0));
      lit(19, M_HB | M_RDY, mk(0, 0, 0, 8'h02, 1, 0, 0));
      lit(20, M_HB | M_RDY | M_ERR, mk(0, 0, 0, 8'hFF, 0, 0, 1));
      lit(21, M_HB | M_ERR, mk(0, 0, 0, 8'hFF, 0, 0, 0));
      lit(23, M_OE | M_HB, mk(0, 0, 1, 8'hFF, 0, 0, 0));
      lit(24, M_OE, mk(0, 0, 0, 8'h00, 0, 0, 0));
      lit(32, M_BUSY, mk(0, 0, 0, 8'h00, 0, 0, 0));
      pay[0] = 8'h81; pay[1] = 8'h02; pay[2] = 8'h33; pay[3] = 8'h44;
      run_burst(4, 2, -1, 1'b0, 1'b0);

      // underflow in SYNC: trail from SYNC_BYTE bit 7
      clr_lit();
      lit(17, M_HB | M_RDY, mk(0, 0, 0, 8'hB8, 1, 0, 0));
      lit(18, M_OE | M_HB | M_ERR, mk(0, 0, 1, 8'h00, 0, 0, 1));
      lit(19, M_ERR, mk(0, 0, 0, 8'h00, 0, 0, 0));
      pay[0] = 8'hAA;
      run_burst(1, 0, -1, 1'b0, 1'b0);

      // reset mid-DATA
      clr_lit();
      lit(19, M_HB | M_BUSY, mk(0, 0, 0, 8'h02, 0, 1, 0));
      lit(20, M_ALL, mk(1, 1, 0, 8'h00, 0, 0, 0));
      pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
      run_burst(4, -1, 19, 1'b0, 1'b0);

      // normal burst after the reset
      clr_lit();
      lit(17, M_HB, mk(0, 0, 0, 8'hB8, 0, 0, 0));
      lit(18, M_HB, mk(0, 0, 0, 8'h5A, 0, 0, 0));
      lit(19, M_HB | M_RDY, mk(0, 0, 0, 8'hA5, 0, 0, 0));
      lit(20, M_HB | M_OE, mk(0, 0, 1, 8'h00, 0, 0, 0));
      pay[0] = 8'h5A; pay[1] = 8'hA5;
      run_burst(2, -1, -1, 1'b0, 1'b0);

      // tx_req held high: back-to-back single-byte bursts
      clr_lit();
      lit(18, M_HB, mk(0, 0, 0, 8'h3C, 0, 0, 0));
      lit(19, M_HB, mk(0, 0, 0, 8'hFF, 0, 0, 0));
      lit(22, M_OE, mk(0, 0, 1, 8'h00, 0, 0, 0));
      lit(23, M_OE | M_LP, mk(1, 1, 0, 8'h00, 0, 0, 0));
      lit(30, M_BUSY | M_LP, mk(1, 1, 0, 8'h00, 0, 1, 0));
      lit(31, M_BUSY | M_LP, mk(1, 1, 0, 8'h00, 0, 0, 0));
      pay[0] = 8'h3C;
      run_burst(1, -1, -1, 1'b1, 1'b0);
      clr_lit();
      lit(1,  M_LP | M_BUSY, mk(0, 1, 0, 8'h00, 0, 1, 0));
      lit(17, M_HB, mk(0, 0, 0, 8'hB8, 0, 0, 0));
      lit(18, M_HB | M_RDY, mk(0, 0, 0, 8'hC3, 0, 0, 0));
      lit(19, M_HB, mk(0, 0, 0, 8'h00, 0, 0, 0));
      pay[0] = 8'hC3;
      run_burst(1, -1, -1, 1'b0, 1'b1);

      repeat (4) step(acc);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
